// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op classes, fixed pipeline latencies and the
// completion-slot record used by the issue scoreboard.
package fpu_pkg;

  localparam int DSIZE = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_CMP = 2'b10,
    OP_RSV = 2'b11
  } fpu_op_e;

  localparam int LAT_ADD = 3;
  localparam int LAT_MUL = 4;
  localparam int LAT_CMP = 1;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    fpu_op_e    op;
  } slot_t;

  // Reserved ops report latency 0 so they never map onto a slot.
  function automatic int op_latency(input fpu_op_e op);
    case (op)
      OP_ADD:  return LAT_ADD;
      OP_MUL:  return LAT_MUL;
      OP_CMP:  return LAT_CMP;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_latency_shifter.sv
// Completion-slot array: every cycle slot k takes slot k+1, and a new op is
// dropped into slot L-1 so it reaches slot 0 exactly L cycles after issue.
module fpu_latency_shifter
  import fpu_pkg::*;
#(
  parameter int NSLOT = 4,
  parameter int LW    = $clog2(NSLOT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ins_en,
  input  logic [LW-1:0]         ins_lat,
  input  slot_t                 ins_rec,
  output logic [NSLOT-1:0]      slot_valid,
  output logic [NSLOT-1:0][4:0] slot_rd,
  output logic [1:0]            head_op
);

  slot_t [NSLOT-1:0] slots;
  slot_t [NSLOT-1:0] slot_nxt;

  always_comb begin
    slot_nxt = '0;
    for (int k = 0; k < NSLOT - 1; k++) begin
      slot_nxt[k] = slots[k+1];
    end
    // Scoreboard guarantees the target slot's incoming occupant is empty.
    if (ins_en) begin
      for (int k = 0; k < NSLOT; k++) begin
        if (int'(ins_lat) == k + 1) slot_nxt[k] = ins_rec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '0;
    end else if (flush) begin
      slots <= '0;
    end else begin
      slots <= slot_nxt;
    end
  end

  always_comb begin
    for (int k = 0; k < NSLOT; k++) begin
      slot_valid[k] = slots[k].valid;
      slot_rd[k]    = slots[k].rd;
    end
    head_op = slots[0].op;
  end

endmodule

// File: rtl/fpu_issue_scoreboard.sv
// FPU issue scoreboard: RAW / structural / WAW hazard detection against the
// in-flight completion slots; the completion record is taken from slot 0.
module fpu_issue_scoreboard
  import fpu_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int NSLOT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       issue_valid,
  input  logic [1:0] issue_op,
  input  logic [4:0] issue_rd,
  input  logic [4:0] issue_rs1,
  input  logic [4:0] issue_rs2,
  output logic       stall,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic [1:0] wb_op,
  output logic       busy
);

  localparam int LW = $clog2(NSLOT + 1);

  // The slot chain must be deep enough for the slowest op class.
  if (NSLOT < LAT_MUL || DSIZE != fpu_pkg::DSIZE) begin : g_cfg_err
    $error("fpu_issue_scoreboard: NSLOT below max latency or DSIZE differs from fpu_pkg");
  end

  logic [NSLOT-1:0]      slot_valid;
  logic [NSLOT-1:0][4:0] slot_rd;
  logic [1:0]            head_op;
  fpu_op_e               op;
  int                    lat;
  logic                  raw, structural, waw;
  logic                  hazard_en, accept, ins_en;
  slot_t                 ins_rec;

  // Slot 0 is excluded: its result is forwarded this very cycle.
  always_comb begin
    op         = fpu_op_e'(issue_op);
    lat        = op_latency(op);
    raw        = 1'b0;
    structural = 1'b0;
    waw        = 1'b0;
    for (int k = 1; k < NSLOT; k++) begin
      if (slot_valid[k]) begin
        if ((issue_rs1 != 5'd0 && issue_rs1 == slot_rd[k]) ||
            (issue_rs2 != 5'd0 && issue_rs2 == slot_rd[k]))
          raw = 1'b1;
        if (k == lat)
          structural = 1'b1;
        if (issue_rd != 5'd0 && issue_rd == slot_rd[k] && k >= lat)
          waw = 1'b1;
      end
    end
  end

  assign hazard_en = issue_valid & ~rst & ~flush & (op != OP_RSV);
  assign stall     = hazard_en & (raw | structural | waw);
  assign accept    = issue_valid & ~rst & ~flush & ~stall;
  assign ins_en    = accept & (issue_rd != 5'd0) & (op != OP_RSV);
  assign ins_rec   = '{valid: 1'b1, rd: issue_rd, op: op};

  fpu_latency_shifter #(
    .NSLOT (NSLOT),
    .LW    (LW)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .ins_en     (ins_en),
    .ins_lat    (LW'(lat)),
    .ins_rec    (ins_rec),
    .slot_valid (slot_valid),
    .slot_rd    (slot_rd),
    .head_op    (head_op)
  );

  assign wb_valid = slot_valid[0];
  assign wb_rd    = slot_rd[0];
  assign wb_op    = head_op;
  assign busy     = |slot_valid;

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Directed, table-driven bench for fpu_issue_scoreboard: one row per cycle,
// inputs driven after the falling edge and outputs checked before the next rise.
module tb_fpu_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst, flush, issue_valid;
  logic [1:0] issue_op;
  logic [4:0] issue_rd, issue_rs1, issue_rs2;
  logic       stall, wb_valid, busy;
  logic [4:0] wb_rd;
  logic [1:0] wb_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpu_issue_scoreboard #(.DSIZE(32), .NSLOT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_op       (wb_op),
    .busy        (busy)
  );

  typedef struct {
    logic       rst, flush, iv;
    logic [1:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       e_stall, e_wbv;
    logic [4:0] e_rd;
    logic [1:0] e_op;
    logic       e_busy;
    logic       chk_data;
    string      name;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] ADD = 2'b00, MUL = 2'b01, CMP = 2'b10, RSV = 2'b11;

  task automatic add(input logic r, input logic f, input logic iv, input logic [1:0] op,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic es, input logic ev, input logic [4:0] erd,
                     input logic [1:0] eop, input logic eb, input string nm);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.e_stall = es; v.e_wbv = ev; v.e_rd = erd; v.e_op = eop; v.e_busy = eb;
    v.chk_data = ev | r; v.name = nm;
    vecs.push_back(v);
  endtask

  // Idle row: no issue, only outputs checked.
  task automatic idle(input logic ev, input logic [4:0] erd, input logic [1:0] eop,
                      input logic eb, input string nm);
    add(0, 0, 0, ADD, 0, 0, 0, 0, ev, erd, eop, eb, nm);
  endtask

  task automatic check1(input string nm, input string what, input logic [4:0] act,
                        input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s %s: got %0d expected %0d", nm, what, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; flush = v.flush; issue_valid = v.iv; issue_op = v.op;
    issue_rd = v.rd; issue_rs1 = v.rs1; issue_rs2 = v.rs2;
  endtask

  task automatic check_vec(input vec_t v);
    check1(v.name, "stall", {4'd0, stall}, {4'd0, v.e_stall});
    check1(v.name, "wb_valid", {4'd0, wb_valid}, {4'd0, v.e_wbv});
    check1(v.name, "busy", {4'd0, busy}, {4'd0, v.e_busy});
    if (v.chk_data) begin
      check1(v.name, "wb_rd", wb_rd, v.e_rd);
      check1(v.name, "wb_op", {3'd0, wb_op}, {3'd0, v.e_op});
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_op = 2'b00;
    issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;

    //   rst flush iv op   rd  rs1 rs2  stall wbv rd op  busy
    add(1, 0, 0, ADD, 0, 0, 0,  0, 0, 0, ADD, 0, "reset_hold");
    add(1, 0, 1, ADD, 4, 0, 0,  0, 0, 0, ADD, 0, "reset_issue_ignored");
    idle(0, 0, ADD, 0, "after_reset_empty");
    // ADD latency 3
    add(0, 0, 1, ADD, 5, 0, 0,  0, 0, 0, ADD, 0, "lat_c0");
    idle(0, 0, ADD, 1, "lat_c1");
    idle(0, 0, ADD, 1, "lat_c2");
    idle(1, 5, ADD, 1, "lat_c3");
    idle(0, 0, ADD, 0, "lat_c4");
    // RAW on rs1, forwarded once producer sits in slot 0
    add(0, 0, 1, ADD, 5, 0, 0,  0, 0, 0, ADD, 0, "raw_c0");
    add(0, 0, 1, ADD, 6, 5, 0,  1, 0, 0, ADD, 1, "raw_c1");
    add(0, 0, 1, ADD, 6, 5, 0,  1, 0, 0, ADD, 1, "raw_c2");
    add(0, 0, 1, ADD, 6, 5, 0,  0, 1, 5, ADD, 1, "raw_c3");
    idle(0, 0, ADD, 1, "raw_c4");
    idle(0, 0, ADD, 1, "raw_c5");
    idle(1, 6, ADD, 1, "raw_c6");
    idle(0, 0, ADD, 0, "raw_c7");
    // structural: ADD would land where MUL shifts into
    add(0, 0, 1, MUL, 7, 0, 0,  0, 0, 0, ADD, 0, "str_c0");
    add(0, 0, 1, ADD, 8, 0, 0,  1, 0, 0, ADD, 1, "str_c1");
    add(0, 0, 1, ADD, 8, 0, 0,  0, 0, 0, ADD, 1, "str_c2");
    idle(0, 0, ADD, 1, "str_c3");
    idle(1, 7, MUL, 1, "str_c4");
    idle(1, 8, ADD, 1, "str_c5");
    idle(0, 0, ADD, 0, "str_c6");
    // WAW: fast CMP must not overtake MUL to the same rd
    add(0, 0, 1, MUL, 9, 0, 0,  0, 0, 0, ADD, 0, "waw_c0");
    add(0, 0, 1, CMP, 9, 0, 0,  1, 0, 0, ADD, 1, "waw_c1");
    add(0, 0, 1, CMP, 9, 0, 0,  1, 0, 0, ADD, 1, "waw_c2");
    add(0, 0, 1, CMP, 9, 0, 0,  1, 0, 0, ADD, 1, "waw_c3");
    add(0, 0, 1, CMP, 9, 0, 0,  0, 1, 9, MUL, 1, "waw_c4");
    idle(1, 9, CMP, 1, "waw_c5");
    idle(0, 0, ADD, 0, "waw_c6");
    // flush kills in-flight op
    add(0, 0, 1, ADD, 3, 0, 0,  0, 0, 0, ADD, 0, "flush_c0");
    add(0, 1, 0, ADD, 0, 0, 0,  0, 0, 0, ADD, 1, "flush_c1");
    idle(0, 0, ADD, 0, "flush_c2");
    idle(0, 0, ADD, 0, "flush_c3");
    idle(0, 0, ADD, 0, "flush_c4");
    idle(0, 0, ADD, 0, "flush_c5");
    // flush with a hazarding same-cycle issue: no stall, issue discarded
    add(0, 0, 1, ADD, 5, 0, 0,  0, 0, 0, ADD, 0, "flush_iss_c0");
    add(0, 1, 1, ADD, 6, 5, 0,  0, 0, 0, ADD, 1, "flush_iss_c1");
    idle(0, 0, ADD, 0, "flush_iss_c2");
    idle(0, 0, ADD, 0, "flush_iss_c3");
    idle(0, 0, ADD, 0, "flush_iss_c4");
    // rd=0 accepted but never written back
    add(0, 0, 1, ADD, 0, 0, 0,  0, 0, 0, ADD, 0, "rd0_c0");
    idle(0, 0, ADD, 0, "rd0_c1");
    idle(0, 0, ADD, 0, "rd0_c2");
    idle(0, 0, ADD, 0, "rd0_c3");
    // reserved op: no hazard check, no slot
    add(0, 0, 1, ADD, 5, 0, 0,  0, 0, 0, ADD, 0, "rsv_c0");
    add(0, 0, 1, RSV, 5, 5, 5,  0, 0, 0, ADD, 1, "rsv_c1");
    idle(0, 0, ADD, 1, "rsv_c2");
    idle(1, 5, ADD, 1, "rsv_c3");
    idle(0, 0, ADD, 0, "rsv_c4");
    // CMP latency 1, then rs2 RAW against a MUL
    add(0, 0, 1, CMP, 12, 0, 0, 0, 0, 0, ADD, 0, "cmp_c0");
    add(0, 0, 1, MUL, 20, 0, 0, 0, 1, 12, CMP, 1, "cmp_c1");
    add(0, 0, 1, ADD, 21, 0, 20, 1, 0, 0, ADD, 1, "rs2_c2");
    add(0, 0, 1, ADD, 21, 0, 20, 1, 0, 0, ADD, 1, "rs2_c3");
    add(0, 0, 1, ADD, 21, 0, 20, 1, 0, 0, ADD, 1, "rs2_c4");
    add(0, 0, 1, ADD, 21, 0, 20, 0, 1, 20, MUL, 1, "rs2_c5");
    idle(0, 0, ADD, 1, "rs2_c6");
    idle(0, 0, ADD, 1, "rs2_c7");
    idle(1, 21, ADD, 1, "rs2_c8");
    idle(0, 0, ADD, 0, "rs2_c9");

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_vec(vecs[i]);
    end

    // Mid-operation reset drops an in-flight MUL.
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; issue_valid = 1'b1; issue_op = MUL; issue_rd = 5'd13;
    issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    #1;
    check1("midrst_c0", "stall", {4'd0, stall}, 5'd0);
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    check1("midrst_c1", "busy", {4'd0, busy}, 5'd1);
    @(negedge clk);
    rst = 1'b1; issue_valid = 1'b1; issue_op = ADD; issue_rd = 5'd13;
    #1;
    check1("midrst_c2", "stall", {4'd0, stall}, 5'd0);
    check1("midrst_c2", "busy", {4'd0, busy}, 5'd1);
    @(negedge clk);
    rst = 1'b0; issue_valid = 1'b0;
    #1;
    check1("midrst_c3", "busy", {4'd0, busy}, 5'd0);
    for (int c = 4; c < 8; c++) begin
      @(negedge clk);
      #1;
      check1($sformatf("midrst_c%0d", c), "wb_valid", {4'd0, wb_valid}, 5'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
